// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: 32-bit radix-2 restoring divider for the EX stage.
// Handles DIV/DIVU/REM/REMU. result_o = {remainder, quotient}.
// One iteration per cycle for 32 cycles, then one END cycle that
// registers the sign-corrected result and raises ready_o.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the
// iterations (FREE -> BYZERO -> END). Without it, a zero divisor runs
// the normal 32 cycles and the END stage forces the zero-divisor result.
module ex_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] ON     = 2'd2;
    localparam logic [1:0] END    = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [5:0]  cnt_q,       cnt_d;
    logic [31:0] rem_q,       rem_d;       // partial remainder
    logic [31:0] quo_q,       quo_d;       // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs_q,       dvs_d;       // divisor magnitude
    logic [31:0] dvd_orig_q,  dvd_orig_d;  // dividend as presented, for the zero-divisor result
    logic        dvd_neg_q,   dvd_neg_d;
    logic        dvs_neg_q,   dvs_neg_d;
    logic        sgn_q,       sgn_d;
    logic        dvs_zero_q,  dvs_zero_d;
    logic [63:0] result_q,    result_d;
    logic        ready_q,     ready_d;

    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] final_res;

    // One restoring step plus operand magnitudes and final sign correction.
    always_comb begin
        trial     = {rem_q, quo_q[31]};
        diff      = trial - {1'b0, dvs_q};
        dvd_mag   = (signed_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
        dvs_mag   = (signed_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
        quo_fix   = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? (32'd0 - quo_q) : quo_q;
        rem_fix   = (sgn_q && dvd_neg_q) ? (32'd0 - rem_q) : rem_q;
        final_res = dvs_zero_q ? {dvd_orig_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
    end

    // Next-state and datapath update for the divide sequence.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dvd_orig_d = dvd_orig_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        sgn_d      = sgn_q;
        dvs_zero_d = dvs_zero_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    rem_d      = 32'd0;
                    quo_d      = dvd_mag;
                    dvs_d      = dvs_mag;
                    dvd_orig_d = opdata1_i;
                    dvd_neg_d  = signed_i & opdata1_i[31];
                    dvs_neg_d  = signed_i & opdata2_i[31];
                    sgn_d      = signed_i;
                    dvs_zero_d = (opdata2_i == 32'd0);
                    cnt_d      = 6'd0;
`ifdef DIV_ZERO_FAST_EN
                    state_d    = (opdata2_i == 32'd0) ? BYZERO : ON;
`else
                    state_d    = ON;
`endif
                end
            end
            BYZERO: begin
                state_d = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = END;
                    end
                end
            end
            default: begin // END: hold the result while EX keeps start_i high
                if (start_i) begin
                    result_d = final_res;
                    ready_d  = 1'b1;
                end else begin
                    state_d  = FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: these are plain flops (no memory array), so every one is reset to keep outputs and state defined.
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= 6'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            dvd_orig_q <= 32'd0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            sgn_q      <= 1'b0;
            dvs_zero_q <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dvd_orig_q <= dvd_orig_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            sgn_q      <= sgn_d;
            dvs_zero_q <= dvs_zero_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Stall the pipeline from an accepted request until the result cycle.
    always_comb begin
        stallreq_o = (state_q == ON) || (state_q == BYZERO) ||
                     ((state_q == FREE) && start_i && !annul_i);
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed self-checking bench for ex_div_ctrl.
// Expected zero-divisor latency follows the DIV_ZERO_FAST_EN build macro.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam int LAT_NORM = 34;  // edges from the start edge until ready_o is seen
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_ZERO = 3;
`else
    localparam int LAT_ZERO = 34;
`endif

    ex_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request/response handshake with latency and result checks.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        lat       = 0;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        #1;
        check({tag, " stall_at_req"}, 64'(stallreq_o), 64'd1);
        while (!ready_o && lat < 60) begin
            tick();
            lat++;
            if (lat == 1) check({tag, " result_zero_busy"}, result_o, 64'd0);
            if (lat == 2 && exp_lat > 3) check({tag, " stall_busy"}, 64'(stallreq_o), 64'd1);
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        check({tag, " stall_end"}, 64'(stallreq_o), 64'd0);
        start_i   = 1'b0;
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0BAD_F00D;
        tick();
        check({tag, " ready_drop"}, 64'(ready_o), 64'd0);
        check({tag, " result_clear"}, result_o, 64'd0);
        tick();
    endtask

    initial begin
        int seen_ready;
        int lat;
        rst       = 1'b0;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        #12;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset stall", 64'(stallreq_o), 64'd0);
        rst = 1'b1;
        tick();

        do_div("divu_100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, LAT_NORM);
        do_div("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, LAT_NORM);
        do_div("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, LAT_NORM);
        do_div("div_m8_m3",    1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFFFFFE_00000002, LAT_NORM);
        do_div("divu_fff9_2",  1'b0, 32'hFFFF_FFF9, 32'd2,         64'h00000001_7FFFFFFC, LAT_NORM);
        do_div("divu_max_16",  1'b0, 32'hFFFF_FFFF, 32'h10,        64'h0000000F_0FFFFFFF, LAT_NORM);
        do_div("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, LAT_NORM);
        do_div("divu_zero",    1'b0, 32'h1234_5678, 32'd0,         64'h12345678_FFFFFFFF, LAT_ZERO);
        do_div("div_zero_neg", 1'b1, 32'h8000_0001, 32'd0,         64'h80000001_FFFFFFFF, LAT_ZERO);

        // Request with annul in FREE is not accepted.
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        #1;
        check("free_annul stall", 64'(stallreq_o), 64'd0);
        tick(); tick(); tick();
        check("free_annul stays_free", 64'(stallreq_o), 64'd0);
        check("free_annul ready", 64'(ready_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        tick();

        // Annul at the tenth ON cycle.
        start_i = 1'b1;
        tick();
        repeat (9) tick();
        check("annul on_stall", 64'(stallreq_o), 64'd1);
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        check("annul free_stall", 64'(stallreq_o), 64'd0);
        seen_ready = 0;
        repeat (40) begin
            tick();
            if (ready_o) seen_ready = 1;
        end
        check("annul no_ready", 64'(seen_ready), 64'd0);
        do_div("after_annul_5_5", 1'b0, 32'd5, 32'd5, 64'h00000000_00000001, LAT_NORM);

        // Reset at the twentieth ON cycle.
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (20) tick();
        #2;
        rst = 1'b0; start_i = 1'b0;
        #1;
        check("rst_on ready", 64'(ready_o), 64'd0);
        check("rst_on result", result_o, 64'd0);
        check("rst_on stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        do_div("after_rst_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, LAT_NORM);

        // Reset while the result is being presented clears it at once.
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1;
        lat = 0;
        while (!ready_o && lat < 60) begin
            tick();
            lat++;
        end
        check("rst_end result_before", result_o, 64'h00000002_0000000E);
        #2;
        rst = 1'b0;
        #1;
        check("rst_end ready", 64'(ready_o), 64'd0);
        check("rst_end result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
